// File: rtl/clock_resets_domain_sequencer_if.sv
// clock_resets_domain_sequencer_if: lock/request inputs and reset bundle outputs of one domain sequencer
interface clock_resets_domain_sequencer_if;
  logic       i_locked;
  logic       i_sw_reset_req;
  logic       o_interconnect_resetn;
  logic       o_peripheral_resetn;
  logic       o_peripheral_reset;
  logic [1:0] o_state;
  modport master (
    output i_locked, i_sw_reset_req,
    input  o_interconnect_resetn, o_peripheral_resetn, o_peripheral_reset, o_state
  );
  modport slave (
    input  i_locked, i_sw_reset_req,
    output o_interconnect_resetn, o_peripheral_resetn, o_peripheral_reset, o_state
  );
endinterface

// File: rtl/clock_resets_domain_sequencer.sv
// clock_resets_domain_sequencer: lock-synchronised, hold-timed interconnect-then-peripheral reset release for one domain
module clock_resets_domain_sequencer #(
  parameter int SYNC_STAGES         = 3,
  parameter int HOLD_CYCLES         = 16,
  parameter int IC_TO_PERIPH_CYCLES = 8
) (
  input logic i_clk,
  input logic i_reset,
  clock_resets_domain_sequencer_if.slave bus
);
  localparam int MAXC = HOLD_CYCLES > IC_TO_PERIPH_CYCLES ? HOLD_CYCLES : IC_TO_PERIPH_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [1:0] {HOLD = 2'd0, REL_IC = 2'd1, RUN = 2'd2} state_t;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ic_rstn_q, per_rstn_q, per_rst_q;
  logic                   abort;
  // lock loss and software request share one path: they clear HOLD and abort REL_IC/RUN
  assign abort = !sync_q[SYNC_STAGES-1] || bus.i_sw_reset_req;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q     <= '0;
      state_q    <= HOLD;
      cnt_q      <= '0;
      ic_rstn_q  <= 1'b0;
      per_rstn_q <= 1'b0;
      per_rst_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_locked};
      if (abort) begin
        state_q    <= HOLD;
        cnt_q      <= '0;
        ic_rstn_q  <= 1'b0;
        per_rstn_q <= 1'b0;
        per_rst_q  <= 1'b1;
      end else begin
        case (state_q)
          HOLD:
            if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
              state_q   <= REL_IC;
              cnt_q     <= '0;
              ic_rstn_q <= 1'b1;
            end else cnt_q <= cnt_q + 1'b1;
          REL_IC:
            if (cnt_q == CW'(IC_TO_PERIPH_CYCLES - 1)) begin
              state_q    <= RUN;
              cnt_q      <= '0;
              per_rstn_q <= 1'b1;
              per_rst_q  <= 1'b0;
            end else cnt_q <= cnt_q + 1'b1;
          default: cnt_q <= '0;
        endcase
      end
    end
  end
  assign bus.o_interconnect_resetn = ic_rstn_q;
  assign bus.o_peripheral_resetn   = per_rstn_q;
  assign bus.o_peripheral_reset    = per_rst_q;
  assign bus.o_state               = state_q;
endmodule

// File: tb/tb_clock_resets_domain_sequencer.sv
// tb_clock_resets_domain_sequencer: vector table, async-reset sequence and random lock/request traffic against a release-count model
module tb_clock_resets_domain_sequencer;
  localparam int S = 3, H = 16, P = 8;
  logic clk = 1'b0, rst = 1'b1;
  int   nvec = 0, nbad = 0;
  clock_resets_domain_sequencer_if bus ();
  clock_resets_domain_sequencer #(.SYNC_STAGES(S), .HOLD_CYCLES(H), .IC_TO_PERIPH_CYCLES(P))
    dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic       lk;
    logic       sw;
    int         cyc;
    logic [1:0] st;
    logic       icn;
    logic       pern;
  } vec_t;
  vec_t tv[$];
  // model: n = consecutive edges with a good lock and no request; the state follows from n alone
  int         n_m;
  logic [S-1:0] lk_hist;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_m     <= 0;
      lk_hist <= '0;
    end else begin
      n_m     <= (!lk_hist[S-1] || bus.i_sw_reset_req) ? 0 : (n_m < H + P ? n_m + 1 : n_m);
      lk_hist <= {lk_hist[S-2:0], bus.i_locked};
    end
  end
  function automatic logic [4:0] exp_of(int n);
    logic [1:0] st;
    st = n < H ? 2'd0 : (n < H + P ? 2'd1 : 2'd2);
    return {st, n >= H, n >= H + P, n < H + P};
  endfunction
  function automatic logic [4:0] act();
    return {bus.o_state, bus.o_interconnect_resetn, bus.o_peripheral_resetn, bus.o_peripheral_reset};
  endfunction
  task automatic chk(string name, logic [4:0] a, logic [4:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s t=%0t got {st,icn,pern,per}=%b expected %b", name, $time, a, e);
    end
  endtask
  always @(negedge clk) begin
    chk("model", act(), exp_of(n_m));
    nvec++;
    if (bus.o_peripheral_resetn && !bus.o_interconnect_resetn) begin
      nbad++;
      $display("FAIL order t=%0t pern=1 while icn=0", $time);
    end
  end
  task automatic tick(int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic run_vec(int i);
    bus.i_locked       = tv[i].lk;
    bus.i_sw_reset_req = tv[i].sw;
    tick(tv[i].cyc);
    chk($sformatf("vec%0d", i), act(), {tv[i].st, tv[i].icn, tv[i].pern, ~tv[i].pern});
  endtask
  initial begin
    // power-up release, lock drop, sw pulse in RUN and REL_IC, long sw hold, lock glitch
    tv.push_back('{1, 0, 18, 0, 0, 0}); tv.push_back('{1, 0, 1, 1, 1, 0});
    tv.push_back('{1, 0, 7, 1, 1, 0});  tv.push_back('{1, 0, 1, 2, 1, 1});
    tv.push_back('{0, 0, 3, 2, 1, 1});  tv.push_back('{0, 0, 1, 0, 0, 0});
    tv.push_back('{0, 0, 1, 0, 0, 0});  tv.push_back('{1, 0, 18, 0, 0, 0});
    tv.push_back('{1, 0, 1, 1, 1, 0});  tv.push_back('{1, 0, 7, 1, 1, 0});
    tv.push_back('{1, 0, 1, 2, 1, 1});  tv.push_back('{1, 1, 1, 0, 0, 0});
    tv.push_back('{1, 0, 15, 0, 0, 0}); tv.push_back('{1, 0, 1, 1, 1, 0});
    tv.push_back('{1, 0, 3, 1, 1, 0});  tv.push_back('{1, 1, 1, 0, 0, 0});
    tv.push_back('{1, 0, 15, 0, 0, 0}); tv.push_back('{1, 0, 1, 1, 1, 0});
    tv.push_back('{1, 0, 7, 1, 1, 0});  tv.push_back('{1, 0, 1, 2, 1, 1});
    tv.push_back('{1, 1, 40, 0, 0, 0}); tv.push_back('{1, 0, 15, 0, 0, 0});
    tv.push_back('{1, 0, 1, 1, 1, 0});  tv.push_back('{1, 0, 8, 2, 1, 1});
    tv.push_back('{0, 0, 4, 0, 0, 0});  tv.push_back('{0, 0, 6, 0, 0, 0});
    tv.push_back('{1, 0, 8, 0, 0, 0});  tv.push_back('{0, 0, 10, 0, 0, 0});
    tv.push_back('{1, 0, 18, 0, 0, 0}); tv.push_back('{1, 0, 1, 1, 1, 0});
    tv.push_back('{1, 0, 8, 2, 1, 1});
    bus.i_locked       = 1'b1;
    bus.i_sw_reset_req = 1'b0;
    tick(3);
    chk("reset", act(), 5'b00_0_0_1);
    rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) run_vec(i);
    #2 rst = 1'b1;
    #1 chk("async_rst", act(), 5'b00_0_0_1);
    tick(1);
    rst = 1'b0;
    tick(18);
    chk("restart_hold", act(), 5'b00_0_0_1);
    tick(1);
    chk("restart_ic", act(), 5'b01_1_0_1);
    tick(8);
    chk("restart_run", act(), 5'b10_1_1_0);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) bus.i_locked = ~bus.i_locked;
      bus.i_sw_reset_req = ($urandom_range(0, 59) == 0);
      tick(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
